sram_ctrl: RTL and testbench

SRAM_CTRL -- requirements
Module: sram_ctrl

---
 rtl/sram_pkg.sv | 19 +
 rtl/sram_io_buf.sv | 14 +
 rtl/sram_ctrl.sv | 103 ++++++++++
 tb/tb_sram_ctrl.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/sram_pkg.sv
// Shared defaults and FSM encoding for the single-port SRAM controller.
package sram_pkg;

  localparam int unsigned ADDR_W_DEF = 6;
  localparam int unsigned DATA_W_DEF = 8;

  localparam logic [1:0] ST_IDLE_ENC    = 2'd0;
  localparam logic [1:0] ST_WR_ENC      = 2'd1;
  localparam logic [1:0] ST_RD_ADDR_ENC = 2'd2;
  localparam logic [1:0] ST_RD_CAP_ENC  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE    = ST_IDLE_ENC,
    ST_WR      = ST_WR_ENC,
    ST_RD_ADDR = ST_RD_ADDR_ENC,
    ST_RD_CAP  = ST_RD_CAP_ENC
  } state_e;

endpackage

// File: rtl/sram_io_buf.sv
// Tristate driver isolating the shared SRAM data bus from the controller core.
module sram_io_buf #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              drv_en,
  input  logic [DATA_W-1:0] out_data,
  output logic [DATA_W-1:0] in_data,
  inout  wire  [DATA_W-1:0] io_data
);

  assign io_data = drv_en ? out_data : {DATA_W{1'bz}};
  assign in_data = io_data;

endmodule

// File: rtl/sram_ctrl.sv
// Request/response controller for an asynchronous-read, clocked-write static RAM.
// Writes take one bus cycle, reads two (address then capture); all outputs registered.
module sram_ctrl
  import sram_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_wr,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [DATA_W-1:0] i_req_wdata,
  output logic              o_rd_valid,
  output logic [DATA_W-1:0] o_rd_data,
  output logic              o_ce,
  output logic              o_rw,
  output logic [ADDR_W-1:0] o_addr,
  inout  wire  [DATA_W-1:0] io_data
);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rd_data_q, rd_data_d;
  logic                rd_valid_q, rd_valid_d;
  logic                ready_q, ready_d;
  logic                ce_q, ce_d;
  logic                rw_q, rw_d;
  logic                drv_en_q, drv_en_d;
  logic [DATA_W-1:0]   bus_in;

  sram_io_buf #(.DATA_W(DATA_W)) u_io_buf (
    .drv_en   (drv_en_q),
    .out_data (wdata_q),
    .in_data  (bus_in),
    .io_data  (io_data)
  );

  // Next state; bus controls are decoded from the next state so they are flopped.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_req_valid) begin
          addr_d  = i_req_addr;
          wdata_d = i_req_wdata;
          state_d = i_req_wr ? ST_WR : ST_RD_ADDR;
        end
      end
      ST_WR:      state_d = ST_IDLE;
      ST_RD_ADDR: state_d = ST_RD_CAP;
      ST_RD_CAP: begin
        rd_data_d  = bus_in;
        rd_valid_d = 1'b1;
        state_d    = ST_IDLE;
      end
      default:    state_d = ST_IDLE;
    endcase
    ready_d  = (state_d == ST_IDLE);
    ce_d     = (state_d != ST_IDLE);
    rw_d     = (state_d == ST_WR);
    drv_en_d = (state_d == ST_WR);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      ready_q    <= 1'b1;
      ce_q       <= 1'b0;
      rw_q       <= 1'b0;
      drv_en_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      ready_q    <= ready_d;
      ce_q       <= ce_d;
      rw_q       <= rw_d;
      drv_en_q   <= drv_en_d;
    end
  end

  assign o_req_ready = ready_q;
  assign o_rd_valid  = rd_valid_q;
  assign o_rd_data   = rd_data_q;
  assign o_ce        = ce_q;
  assign o_rw        = rw_q;
  assign o_addr      = addr_q;

endmodule

// File: tb/tb_sram_ctrl.sv
// Scoreboard bench for sram_ctrl driving a behavioural static RAM on the shared bus.
module tb_sram_ctrl;

  localparam int unsigned AW = 6;
  localparam int unsigned DW = 8;
  localparam int unsigned DEPTH = 1 << AW;

  logic          i_clk = 1'b0;
  logic          i_reset;
  logic          i_req_valid;
  logic          o_req_ready;
  logic          i_req_wr;
  logic [AW-1:0] i_req_addr;
  logic [DW-1:0] i_req_wdata;
  logic          o_rd_valid;
  logic [DW-1:0] o_rd_data;
  logic          o_ce;
  logic          o_rw;
  logic [AW-1:0] o_addr;
  wire  [DW-1:0] io_data;

  sram_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_req_valid (i_req_valid),
    .o_req_ready (o_req_ready),
    .i_req_wr    (i_req_wr),
    .i_req_addr  (i_req_addr),
    .i_req_wdata (i_req_wdata),
    .o_rd_valid  (o_rd_valid),
    .o_rd_data   (o_rd_data),
    .o_ce        (o_ce),
    .o_rw        (o_rw),
    .o_addr      (o_addr),
    .io_data     (io_data)
  );

  always #5 i_clk = ~i_clk;

  // Behavioural static RAM: combinational read, write commits on the clock edge.
  logic [DW-1:0] sram_mem [DEPTH];
  assign io_data = (o_ce && !o_rw) ? sram_mem[o_addr] : {DW{1'bz}};
  always @(posedge i_clk) if (o_ce && o_rw) sram_mem[o_addr] <= io_data;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;
  int contention = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=0x%0h expected=0x%0h (cyc %0d)", tag, obs, exp, cyc);
    end
  endtask

  typedef struct {
    logic [DW-1:0] data;
    int            cyc;
  } exp_t;
  exp_t          sb_q[$];
  logic [DW-1:0] ref_mem [DEPTH];

  // Response monitor: pops the scoreboard on each read pulse.
  always @(negedge i_clk) begin
    exp_t e;
    if (o_rd_valid) begin
      if (sb_q.size() == 0) begin
        check_eq("rd_valid_unexpected", 32'(o_rd_valid), 32'd0);
      end else begin
        e = sb_q.pop_front();
        check_eq("rd_data", 32'(o_rd_data), 32'(e.data));
        check_eq("rd_latency", 32'(cyc), 32'(e.cyc));
      end
    end else if (sb_q.size() != 0 && cyc > sb_q[0].cyc) begin
      check_eq("rd_valid_missing", 32'(o_rd_valid), 32'd1);
      void'(sb_q.pop_front());
    end
    if (dut.u_io_buf.drv_en && !(o_ce && o_rw)) contention++;
  end

  // Presents a request (valid stays high afterwards) and returns after its acceptance edge.
  task automatic issue(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                       output int acc);
    int waited;
    waited = 0;
    @(negedge i_clk);
    i_req_valid = 1'b1;
    i_req_wr    = wr;
    i_req_addr  = addr;
    i_req_wdata = data;
    while (!o_req_ready && waited < 10) begin
      @(negedge i_clk);
      waited++;
    end
    if (waited >= 10) check_eq("req_ready_timeout", 32'(o_req_ready), 32'd1);
    acc = cyc;
    if (wr) ref_mem[addr] = data;
    else    sb_q.push_back('{data: ref_mem[addr], cyc: acc + 3});
    @(posedge i_clk);
  endtask

  task automatic idle(input int n);
    @(negedge i_clk);
    i_req_valid = 1'b0;
    repeat (n) @(negedge i_clk);
  endtask

  initial begin
    int acc, prev, waited;
    i_reset = 1'b1;
    i_req_valid = 1'b1;
    i_req_wr = 1'b1;
    i_req_addr = AW'(7);
    i_req_wdata = DW'(8'h77);

    // Reset values, with a request held during reset that must be ignored
    repeat (3) @(negedge i_clk);
    check_eq("rst_ready", 32'(o_req_ready), 32'd1);
    check_eq("rst_rd_valid", 32'(o_rd_valid), 32'd0);
    check_eq("rst_rd_data", 32'(o_rd_data), 32'd0);
    check_eq("rst_ce", 32'(o_ce), 32'd0);
    check_eq("rst_rw", 32'(o_rw), 32'd0);
    check_eq("rst_addr", 32'(o_addr), 32'd0);
    check_eq("rst_drv_en", 32'(dut.u_io_buf.drv_en), 32'd0);
    i_reset = 1'b0;
    i_req_valid = 1'b0;
    @(negedge i_clk);
    check_eq("post_rst_ce", 32'(o_ce), 32'd0);
    check_eq("post_rst_ready", 32'(o_req_ready), 32'd1);

    // Single write then read at 0x05
    issue(1'b1, AW'(5), DW'(8'hA5), acc);
    @(negedge i_clk);
    check_eq("wr_ce", 32'(o_ce), 32'd1);
    check_eq("wr_rw", 32'(o_rw), 32'd1);
    check_eq("wr_addr", 32'(o_addr), 32'h05);
    check_eq("wr_bus", 32'(io_data), 32'hA5);
    i_req_valid = 1'b0;
    issue(1'b0, AW'(5), DW'(0), acc);
    idle(5);

    // Address boundaries, no aliasing
    issue(1'b1, AW'(6'h3F), DW'(8'hFF), acc);
    issue(1'b1, AW'(0), DW'(8'h01), acc);
    issue(1'b0, AW'(6'h3F), DW'(0), acc);
    issue(1'b0, AW'(0), DW'(0), acc);
    idle(5);

    // Back-to-back fill then read-all with throughput checks
    prev = 0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      issue(1'b1, AW'(i), DW'(i + 1), acc);
      if (i > 0) check_eq("wr_interval", 32'(acc - prev), 32'd2);
      prev = acc;
    end
    for (int i = 0; i < int'(DEPTH); i++) begin
      issue(1'b0, AW'(i), DW'(0), acc);
      if (i > 0) check_eq("rd_interval", 32'(acc - prev), 32'd3);
      prev = acc;
    end
    idle(5);

    // Valid held high through a read: ready low in RD_ADDR and RD_CAP
    issue(1'b0, AW'(9), DW'(0), acc);
    prev = acc;
    @(negedge i_clk);
    check_eq("hold_ready_rd_addr", 32'(o_req_ready), 32'd0);
    check_eq("hold_rd_addr_ce", 32'(o_ce), 32'd1);
    check_eq("hold_rd_addr_rw", 32'(o_rw), 32'd0);
    @(negedge i_clk);
    check_eq("hold_ready_rd_cap", 32'(o_req_ready), 32'd0);
    check_eq("hold_rd_cap_addr", 32'(o_addr), 32'd9);
    issue(1'b0, AW'(10), DW'(0), acc);
    check_eq("hold_rd_interval", 32'(acc - prev), 32'd3);
    idle(5);

    // Reset during RD_CAP aborts the read
    issue(1'b0, AW'(20), DW'(0), acc);
    @(negedge i_clk);
    i_req_valid = 1'b0;
    @(negedge i_clk);
    i_reset = 1'b1;
    void'(sb_q.pop_back());
    @(negedge i_clk);
    check_eq("abort_rd_valid", 32'(o_rd_valid), 32'd0);
    check_eq("abort_ce", 32'(o_ce), 32'd0);
    check_eq("abort_ready", 32'(o_req_ready), 32'd1);
    i_reset = 1'b0;
    repeat (4) @(negedge i_clk);
    check_eq("abort_no_pulse", 32'(o_rd_valid), 32'd0);

    // Controller still functional after abort
    issue(1'b0, AW'(20), DW'(0), acc);
    idle(1);

    waited = 0;
    while (sb_q.size() != 0 && waited < 20) begin
      @(negedge i_clk);
      waited++;
    end
    check_eq("sb_drained", 32'(sb_q.size()), 32'd0);
    check_eq("bus_contention", 32'(contention), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
